// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the two-input gate sweeper.
// Truth tables are indexed by vector index {b,a}.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int         VEC_COUNT  = 4;
  localparam logic [3:0] EXPECT_AND = 4'b1000;
  localparam logic [3:0] EXPECT_OR  = 4'b1110;
  localparam logic [3:0] EXPECT_XOR = 4'b0110;

  // A one-cycle settle still needs a 1-bit counter.
  function automatic int timer_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gate_sweeper_settle_timer.sv
// Settle-time down-counter: loaded with SETTLE_CYCLES-1, counts to zero while enabled.
// expired flags terminal count so the FSM can move on to the sampling edge.
module settle_timer
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int            W        = timer_width(SETTLE_CYCLES);
  localparam logic [W-1:0]  LOAD_VAL = W'(SETTLE_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/gate_sweeper.sv
// Drives a two-input gate through all four input vectors, samples its output after
// a settle time and reports per-vector mismatches against an expected truth table.
//
// state  | meaning
// IDLE   | waiting for start, outputs at reset values
// SETTLE | vector idx driven, settle timer running
// SAMPLE | f compared with EXPECT[idx] on the leaving edge
// DONE   | results frozen, vector 3 held, waits for start
module gate_sweeper
  import gate_sweep_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [3:0] EXPECT        = EXPECT_AND
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask,
  output logic [2:0] err_count
);

  state_t     state, state_nxt;
  logic [1:0] idx;
  logic       start_ok;
  logic       last_vec;
  logic       mismatch;
  logic       expired;
  logic       timer_load;
  logic       timer_en;
  logic       busy_nxt;
  logic       done_nxt;

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign last_vec = (idx == 2'(VEC_COUNT - 1));
  assign mismatch = (f != EXPECT[idx]);

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .en     (timer_en),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = SETTLE;
      SETTLE:  if (expired) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_vec ? DONE : SETTLE;
      DONE:    if (start_ok) state_nxt = SETTLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flag values are derived from the next state so busy/done leave a flop directly.
  always_comb begin
    busy_nxt   = (state_nxt == SETTLE) || (state_nxt == SAMPLE);
    done_nxt   = (state_nxt == DONE);
    timer_load = start_ok || ((state == SAMPLE) && !last_vec);
    timer_en   = (state == SETTLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      err_mask  <= '0;
      err_count <= '0;
    end else if (start_ok) begin
      idx       <= '0;
      err_mask  <= '0;
      err_count <= '0;
    end else if (state == SAMPLE) begin
      if (mismatch) begin
        err_mask[idx] <= 1'b1;
        err_count     <= err_count + 3'd1;
      end
      if (!last_vec) begin
        idx <= idx + 2'd1;
      end
    end
  end

  // The vector index register drives the gate inputs directly.
  assign a    = idx[0];
  assign b    = idx[1];
  assign pass = done && (err_count == 3'd0);

endmodule

// File: tb/tb_gate_sweeper.sv
// Self-checking bench for gate_sweeper: table of gate behaviours swept in turn,
// plus hand sequences for reset mid-sweep and the one-cycle settle variant.
module tb_gate_sweeper;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       a, b, f, busy, done, pass;
  logic [3:0] err_mask;
  logic [2:0] err_count;
  logic [2:0] f_mode;

  logic       start1;
  logic       a1, b1, f1, busy1, done1, pass1;
  logic [3:0] err_mask1;
  logic [2:0] err_count1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_sweeper dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .f(f),
    .busy(busy), .done(done), .pass(pass), .err_mask(err_mask), .err_count(err_count)
  );

  gate_sweeper #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .f(f1),
    .busy(busy1), .done(done1), .pass(pass1), .err_mask(err_mask1), .err_count(err_count1)
  );

  // Behaviour of the gate attached to the main instance.
  always_comb begin
    case (f_mode)
      3'd0:    f = a & b;
      3'd1:    f = 1'b0;
      3'd2:    f = 1'b1;
      3'd3:    f = a ^ b;
      3'd4:    f = a | b;
      default: f = a & b;
    endcase
  end
  assign f1 = a1 & b1;

  typedef struct {
    logic [2:0] mode;
    logic [3:0] mask;
    logic [2:0] cnt;
    logic       pass;
    int         repulse;
  } vec_t;

  typedef struct {
    logic [3:0] mask;
    logic [2:0] cnt;
    logic       pass;
  } res_t;

  vec_t tbl[5];
  res_t sb[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input vec_t v);
    res_t exp_res;
    res_t got;
    int   vi;
    f_mode = v.mode;
    exp_res.mask = v.mask;
    exp_res.cnt  = v.cnt;
    exp_res.pass = v.pass;
    sb.push_back(exp_res);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_clear_mask", 8'(err_mask), 8'h0);
    chk("start_clear_count", 8'(err_count), 8'h0);
    chk("start_busy", 8'(busy), 8'h1);
    chk("start_done", 8'(done), 8'h0);
    chk("start_vec", 8'({a, b}), 8'h0);
    for (int k = 1; k <= 20; k++) begin
      if (k == v.repulse) start = 1'b1;
      tick();
      start = 1'b0;
      if (k < 20) begin
        vi = k / 5;
        chk($sformatf("vec_a k=%0d", k), 8'(a), 8'(vi & 1));
        chk($sformatf("vec_b k=%0d", k), 8'(b), 8'((vi >> 1) & 1));
        chk($sformatf("busy k=%0d", k), 8'(busy), 8'h1);
        chk($sformatf("done k=%0d", k), 8'(done), 8'h0);
      end else begin
        chk("final_vec", 8'({a, b}), 8'h3);
        chk("final_busy", 8'(busy), 8'h0);
        chk("final_done", 8'(done), 8'h1);
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 8'h1, 8'h0);
        end else begin
          got = sb.pop_front();
          chk($sformatf("err_mask mode=%0d", v.mode), 8'(err_mask), 8'(got.mask));
          chk($sformatf("err_count mode=%0d", v.mode), 8'(err_count), 8'(got.cnt));
          chk($sformatf("pass mode=%0d", v.mode), 8'(pass), 8'(got.pass));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{mode: 3'd0, mask: 4'b0000, cnt: 3'd0, pass: 1'b1, repulse: 7};
    tbl[1] = '{mode: 3'd1, mask: 4'b1000, cnt: 3'd1, pass: 1'b0, repulse: 0};
    tbl[2] = '{mode: 3'd2, mask: 4'b0111, cnt: 3'd3, pass: 1'b0, repulse: 13};
    tbl[3] = '{mode: 3'd3, mask: 4'b1110, cnt: 3'd3, pass: 1'b0, repulse: 0};
    tbl[4] = '{mode: 3'd4, mask: 4'b0110, cnt: 3'd2, pass: 1'b0, repulse: 0};

    reset  = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    f_mode = 3'd0;
    repeat (3) tick();
    chk("reset_vec", 8'({a, b}), 8'h0);
    chk("reset_busy", 8'(busy), 8'h0);
    chk("reset_done", 8'(done), 8'h0);
    chk("reset_pass", 8'(pass), 8'h0);
    chk("reset_mask", 8'(err_mask), 8'h0);
    chk("reset_count", 8'(err_count), 8'h0);
    reset = 1'b0;
    repeat (2) tick();
    chk("idle_busy", 8'(busy), 8'h0);

    for (int i = 0; i < 5; i++) sweep(tbl[i]);

    // A few more idle cycles in DONE: results must stay frozen.
    repeat (4) tick();
    chk("done_hold", 8'(done), 8'h1);
    chk("done_hold_mask", 8'(err_mask), 8'h6);

    // Reset mid-sweep while vector 2 is driven, with partial errors recorded.
    f_mode = 3'd2;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("pre_reset_b", 8'(b), 8'h1);
    chk("pre_reset_mask", 8'(err_mask), 8'h3);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_a", 8'(a), 8'h0);
    chk("async_reset_b", 8'(b), 8'h0);
    chk("async_reset_busy", 8'(busy), 8'h0);
    chk("async_reset_mask", 8'(err_mask), 8'h0);
    chk("async_reset_count", 8'(err_count), 8'h0);
    tick();
    reset = 1'b0;
    repeat (25) tick();
    chk("post_reset_idle_busy", 8'(busy), 8'h0);
    chk("post_reset_idle_done", 8'(done), 8'h0);
    chk("post_reset_idle_vec", 8'({a, b}), 8'h0);

    // One-cycle settle: each vector held two cycles, done at E8.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("s1_start_busy", 8'(busy1), 8'h1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        chk($sformatf("s1_vec k=%0d", k), 8'({b1, a1}), 8'(k / 2));
        chk($sformatf("s1_done k=%0d", k), 8'(done1), 8'h0);
      end else begin
        chk("s1_done", 8'(done1), 8'h1);
        chk("s1_busy", 8'(busy1), 8'h0);
        chk("s1_pass", 8'(pass1), 8'h1);
        chk("s1_mask", 8'(err_mask1), 8'h0);
        chk("s1_count", 8'(err_count1), 8'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
